// File: rtl/gomoku_pkg.sv
// Shared Gomoku types and helpers, common to the board controller and the pixel generator.
package gomoku_pkg;

  localparam int BOARD_N = 6;
  localparam int CELLS   = BOARD_N * BOARD_N;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    DIR_H = 2'b00,
    DIR_V = 2'b01,
    DIR_D = 2'b10,
    DIR_A = 2'b11
  } dir_t;

  // Per-axis unit step: 00 stay, 01 plus one, 11 minus one.
  typedef logic [1:0] delta_t;
  localparam delta_t D_ZERO  = 2'b00;
  localparam delta_t D_PLUS  = 2'b01;
  localparam delta_t D_MINUS = 2'b11;

  typedef logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_t;

  function automatic delta_t row_delta(input dir_t d);
    case (d)
      DIR_H:   row_delta = D_ZERO;
      default: row_delta = D_PLUS;
    endcase
  endfunction

  function automatic delta_t col_delta(input dir_t d);
    case (d)
      DIR_H:   col_delta = D_PLUS;
      DIR_V:   col_delta = D_ZERO;
      DIR_D:   col_delta = D_PLUS;
      DIR_A:   col_delta = D_MINUS;
      default: col_delta = D_ZERO;
    endcase
  endfunction

  function automatic delta_t delta_neg(input delta_t d);
    case (d)
      D_PLUS:  delta_neg = D_MINUS;
      D_MINUS: delta_neg = D_PLUS;
      default: delta_neg = D_ZERO;
    endcase
  endfunction

  // True when stepping coordinate p by d stays on the board.
  function automatic logic coord_ok(input logic [2:0] p, input delta_t d);
    case (d)
      D_PLUS:  coord_ok = (p < 3'(BOARD_N - 1));
      D_MINUS: coord_ok = (p != 3'd0);
      default: coord_ok = 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] coord_step(input logic [2:0] p, input delta_t d);
    case (d)
      D_PLUS:  coord_step = p + 3'd1;
      D_MINUS: coord_step = p - 3'd1;
      default: coord_step = p;
    endcase
  endfunction

  function automatic cell_t colour_of(input logic player);
    colour_of = player ? WHITE : BLACK;
  endfunction

endpackage

// File: rtl/gomoku_run_scanner.sv
// Counts the run of same-colour stones through one cell along one line,
// walking one cell per cycle outward, first in the positive then the negative sense.
module gomoku_run_scanner
  import gomoku_pkg::*;
#(
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       start,
  input  logic [2:0] start_row,
  input  logic [2:0] start_col,
  input  dir_t       dir,
  input  cell_t      colour,
  input  board_t     board,
  output logic       done,
  output logic [2:0] run
);

  logic       busy_r;
  logic       neg_phase_r;
  logic       done_r;
  logic [2:0] run_r;
  logic [2:0] pos_row_r;
  logic [2:0] pos_col_r;
  logic [2:0] neg_row_r;
  logic [2:0] neg_col_r;
  delta_t     drow_r;
  delta_t     dcol_r;
  cell_t      colour_r;

  delta_t     ndrow_s;
  delta_t     ndcol_s;
  logic [2:0] pos_next_row_s;
  logic [2:0] pos_next_col_s;
  logic [2:0] neg_next_row_s;
  logic [2:0] neg_next_col_s;
  logic       pos_ok_s;
  logic       neg_ok_s;
  logic       at_max_s;

  // Bounds-check and colour-match the next cell on each side of the run.
  always_comb begin
    ndrow_s        = delta_neg(drow_r);
    ndcol_s        = delta_neg(dcol_r);
    pos_next_row_s = coord_step(pos_row_r, drow_r);
    pos_next_col_s = coord_step(pos_col_r, dcol_r);
    neg_next_row_s = coord_step(neg_row_r, ndrow_s);
    neg_next_col_s = coord_step(neg_col_r, ndcol_s);
    at_max_s       = (run_r == 3'(WIN_LEN));
    pos_ok_s       = 1'b0;
    neg_ok_s       = 1'b0;
    if (coord_ok(pos_row_r, drow_r) && coord_ok(pos_col_r, dcol_r)) begin
      pos_ok_s = (board[pos_next_row_s][pos_next_col_s] == colour_r);
    end else begin
      pos_ok_s = 1'b0;
    end
    if (coord_ok(neg_row_r, ndrow_s) && coord_ok(neg_col_r, ndcol_s)) begin
      neg_ok_s = (board[neg_next_row_s][neg_next_col_s] == colour_r);
    end else begin
      neg_ok_s = 1'b0;
    end
  end

  // Stepping sequencer: load, step while the run continues, then pulse done.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      busy_r      <= 1'b0;
      neg_phase_r <= 1'b0;
      done_r      <= 1'b0;
      run_r       <= 3'd0;
      pos_row_r   <= 3'd0;
      pos_col_r   <= 3'd0;
      neg_row_r   <= 3'd0;
      neg_col_r   <= 3'd0;
      drow_r      <= D_ZERO;
      dcol_r      <= D_ZERO;
      colour_r    <= EMPTY;
    end else if (start) begin
      busy_r      <= 1'b1;
      neg_phase_r <= 1'b0;
      done_r      <= 1'b0;
      run_r       <= 3'd1;
      pos_row_r   <= start_row;
      pos_col_r   <= start_col;
      neg_row_r   <= start_row;
      neg_col_r   <= start_col;
      drow_r      <= row_delta(dir);
      dcol_r      <= col_delta(dir);
      colour_r    <= colour;
    end else if (busy_r) begin
      if (at_max_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else if (!neg_phase_r && pos_ok_s) begin
        pos_row_r <= pos_next_row_s;
        pos_col_r <= pos_next_col_s;
        run_r     <= run_r + 3'd1;
        done_r    <= 1'b0;
      end else if (neg_ok_s) begin
        neg_row_r   <= neg_next_row_s;
        neg_col_r   <= neg_next_col_s;
        neg_phase_r <= 1'b1;
        run_r       <= run_r + 3'd1;
        done_r      <= 1'b0;
      end else begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign run  = run_r;

endmodule

// File: rtl/gomoku_board_ctrl.sv
// Gomoku board controller: accepts alternating moves, stores the 6x6 board
// and runs a four-direction win check after every stone.
module gomoku_board_ctrl
  import gomoku_pkg::*;
#(
  parameter int WIN_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            new_game,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][2:0] req_row,
  input  logic [1:0][2:0] req_col,
  output board_t          board,
  output logic            turn,
  output logic            move_reject,
  output logic [5:0]      move_count,
  output logic            game_over,
  output logic [1:0]      winner
);

  typedef enum logic [1:0] {
    WAIT  = 2'b00,
    CHECK = 2'b01,
    OVER  = 2'b10
  } state_t;

  state_t     state_r;
  board_t     board_r;
  logic       turn_r;
  logic       move_reject_r;
  logic [5:0] move_count_r;
  logic       game_over_r;
  logic [1:0] winner_r;
  dir_t       dir_r;
  logic [2:0] row_r;
  logic [2:0] col_r;
  cell_t      mover_colour_r;

  logic [2:0] sel_row_s;
  logic [2:0] sel_col_s;
  logic       hs_s;
  logic       in_range_s;
  logic       cell_empty_s;
  logic       legal_s;
  logic       scan_start_s;
  dir_t       scan_dir_s;
  logic [2:0] scan_row_s;
  logic [2:0] scan_col_s;
  cell_t      scan_colour_s;
  logic       scan_done_s;
  logic [2:0] scan_run_s;
  logic       scan_win_s;

  // Handshake and legality of the current player's request.
  always_comb begin
    req_ready = 2'b00;
    if ((state_r == WAIT) && !new_game && !rst) begin
      req_ready[turn_r] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
    sel_row_s    = req_row[turn_r];
    sel_col_s    = req_col[turn_r];
    hs_s         = req_valid[turn_r] && req_ready[turn_r];
    in_range_s   = (sel_row_s <= 3'(BOARD_N - 1)) && (sel_col_s <= 3'(BOARD_N - 1));
    cell_empty_s = 1'b0;
    if (in_range_s) begin
      cell_empty_s = (board_r[sel_row_s][sel_col_s] == EMPTY);
    end else begin
      cell_empty_s = 1'b0;
    end
    legal_s = hs_s && in_range_s && cell_empty_s;
  end

  // Scanner launch: first direction on the accepting edge, the next one as each finishes.
  always_comb begin
    scan_win_s = scan_done_s && (scan_run_s == 3'(WIN_LEN));
    if (state_r == WAIT) begin
      scan_start_s  = legal_s;
      scan_dir_s    = DIR_H;
      scan_row_s    = sel_row_s;
      scan_col_s    = sel_col_s;
      scan_colour_s = colour_of(turn_r);
    end else begin
      scan_start_s  = (state_r == CHECK) && scan_done_s && !scan_win_s && (dir_r != DIR_A);
      scan_dir_s    = dir_t'(dir_r + 2'd1);
      scan_row_s    = row_r;
      scan_col_s    = col_r;
      scan_colour_s = mover_colour_r;
    end
  end

  gomoku_run_scanner #(
    .WIN_LEN (WIN_LEN)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .clear     (new_game),
    .start     (scan_start_s),
    .start_row (scan_row_s),
    .start_col (scan_col_s),
    .dir       (scan_dir_s),
    .colour    (scan_colour_s),
    .board     (board_r),
    .done      (scan_done_s),
    .run       (scan_run_s)
  );

  // Game FSM with registered board and status outputs.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state_r        <= WAIT;
      board_r        <= {(2 * CELLS){1'b0}};
      turn_r         <= 1'b0;
      move_reject_r  <= 1'b0;
      move_count_r   <= 6'd0;
      game_over_r    <= 1'b0;
      winner_r       <= 2'b00;
      dir_r          <= DIR_H;
      row_r          <= 3'd0;
      col_r          <= 3'd0;
      mover_colour_r <= EMPTY;
    end else begin
      move_reject_r <= 1'b0;
      case (state_r)
        WAIT: begin
          if (legal_s) begin
            board_r[sel_row_s][sel_col_s] <= colour_of(turn_r);
            move_count_r   <= move_count_r + 6'd1;
            row_r          <= sel_row_s;
            col_r          <= sel_col_s;
            mover_colour_r <= colour_of(turn_r);
            dir_r          <= DIR_H;
            state_r        <= CHECK;
          end else if (hs_s) begin
            move_reject_r <= 1'b1;
          end
        end
        CHECK: begin
          if (scan_done_s) begin
            if (scan_win_s) begin
              state_r     <= OVER;
              game_over_r <= 1'b1;
              winner_r    <= mover_colour_r;
            end else if (dir_r != DIR_A) begin
              dir_r <= dir_t'(dir_r + 2'd1);
            end else if (move_count_r == 6'(CELLS)) begin
              state_r     <= OVER;
              game_over_r <= 1'b1;
              winner_r    <= 2'b00;
            end else begin
              turn_r  <= ~turn_r;
              state_r <= WAIT;
            end
          end
        end
        OVER: begin
          game_over_r <= 1'b1;
        end
        default: begin
          state_r <= WAIT;
        end
      endcase
    end
  end

  assign board       = board_r;
  assign turn        = turn_r;
  assign move_reject = move_reject_r;
  assign move_count  = move_count_r;
  assign game_over   = game_over_r;
  assign winner      = winner_r;

endmodule

// File: tb/tb_gomoku_board_ctrl.sv
// Randomized and directed bench for gomoku_board_ctrl against an array-based rules model.
module tb_gomoku_board_ctrl;
  import gomoku_pkg::*;

  localparam int W           = 4;
  localparam int N           = 6;
  localparam int CHECK_BOUND = 4 * (2 * (W - 1) + 2);

  logic            clk = 1'b0;
  logic            rst;
  logic            new_game;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][2:0] req_row;
  logic [1:0][2:0] req_col;
  board_t          board;
  logic            turn;
  logic            move_reject;
  logic [5:0]      move_count;
  logic            game_over;
  logic [1:0]      winner;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int mb [N][N];
  int m_turn;
  int m_count;
  int m_winner;
  bit m_over;
  int bl[$];
  int wl[$];

  gomoku_board_ctrl #(.WIN_LEN(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .new_game    (new_game),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_row     (req_row),
    .req_col     (req_col),
    .board       (board),
    .turn        (turn),
    .move_reject (move_reject),
    .move_count  (move_count),
    .game_over   (game_over),
    .winner      (winner)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Run-time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mb[r][c] = 0;
    m_turn = 0; m_count = 0; m_winner = 0; m_over = 1'b0;
  endtask

  // Longest line through (r,c) of the given colour reaches W?
  function automatic bit model_line(input int r, input int c, input int colour);
    int dr [4];
    int dc [4];
    int cnt, rr, cc;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      cnt = 1;
      rr = r + dr[d]; cc = c + dc[d];
      while (rr >= 0 && rr < N && cc >= 0 && cc < N && mb[rr][cc] == colour) begin
        cnt++; rr += dr[d]; cc += dc[d];
      end
      rr = r - dr[d]; cc = c - dc[d];
      while (rr >= 0 && rr < N && cc >= 0 && cc < N && mb[rr][cc] == colour) begin
        cnt++; rr -= dr[d]; cc -= dc[d];
      end
      if (cnt >= W) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic compare_all(input string tag);
    board_t eb;
    logic [1:0] er;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) eb[r][c] = 2'(mb[r][c]);
    er = m_over ? 2'b00 : ((m_turn == 1) ? 2'b10 : 2'b01);
    check_eq({tag, "/board"}, 72'(board), 72'(eb));
    check_eq({tag, "/turn"}, 72'(turn), 72'(m_turn));
    check_eq({tag, "/move_count"}, 72'(move_count), 72'(m_count));
    check_eq({tag, "/game_over"}, 72'(game_over), 72'(m_over));
    check_eq({tag, "/winner"}, 72'(winner), 72'(m_winner));
    check_eq({tag, "/req_ready"}, 72'(req_ready), 72'(er));
    check_eq({tag, "/move_reject"}, 72'(move_reject), 72'(0));
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    #1 compare_all("new_game");
  endtask

  // One move by player p; optional abort (new_game or rst) in CHECK cycle abort_k.
  task automatic play(input int p, input int r, input int c, input int abort_k,
                      input bit use_rst, input bit both);
    int n;
    bit legal;
    req_row[p] = 3'(r); req_col[p] = 3'(c); req_valid[p] = 1'b1;
    if (both) begin
      req_row[1-p] = 3'($urandom_range(0, 5));
      req_col[1-p] = 3'($urandom_range(0, 5));
      req_valid[1-p] = 1'b1;
    end
    n = 0;
    while (req_ready[p] !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    check_eq("handshake_wait", 72'(n < 50), 72'(1));
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    legal = 1'b0;
    if (r < N && c < N) legal = (mb[r][c] == 0);
    if (legal) begin
      mb[r][c] = p + 1;
      m_count++;
      check_eq("stone_written", 72'(board[r][c]), 72'(p + 1));
      if (abort_k > 0) begin
        for (int i = 1; i < abort_k; i++) @(negedge clk);
        if (use_rst) rst = 1'b1; else new_game = 1'b1;
        @(negedge clk);
        model_clear();
        if (use_rst) check_eq("ready_in_rst", 72'(req_ready), 72'(0));
        rst = 1'b0; new_game = 1'b0;
        #1 compare_all("abort");
      end else begin
        n = 0;
        while (req_ready == 2'b00 && !game_over && n < 200) begin
          n++; @(negedge clk);
        end
        check_eq("check_resolved", 72'(n < 200), 72'(1));
        check_eq("check_within_bound", 72'(n <= CHECK_BOUND), 72'(1));
        if (model_line(r, c, p + 1)) begin
          m_over = 1'b1; m_winner = p + 1;
        end else if (m_count == N * N) begin
          m_over = 1'b1; m_winner = 0;
        end else begin
          m_turn = 1 - m_turn;
        end
        compare_all("move");
      end
    end else begin
      check_eq("reject_pulse", 72'(move_reject), 72'(1));
      @(negedge clk);
      compare_all("after_reject");
    end
  endtask

  task automatic poke_wrong(input int r, input int c);
    int o;
    o = 1 - m_turn;
    req_row[o] = 3'(r); req_col[o] = 3'(c); req_valid[o] = 1'b1;
    #1 check_eq("wrong_ready", 72'(req_ready[o]), 72'(0));
    repeat (2) @(negedge clk);
    compare_all("wrong_player");
    req_valid[o] = 1'b0;
  endtask

  initial begin
    int x, rr, cc, ak;
    rst = 1'b1; new_game = 1'b0; req_valid = 2'b11; req_row = '0; req_col = '0;
    repeat (3) @(negedge clk);
    check_eq("ready_during_rst", 72'(req_ready), 72'(0));
    rst = 1'b0; req_valid = 2'b00;
    model_clear();
    #1 compare_all("reset");

    // Black row win at (2,0)..(2,3).
    play(0, 2, 0, 0, 0, 0); play(1, 0, 0, 0, 0, 0);
    play(0, 2, 1, 0, 0, 0); play(1, 0, 1, 0, 0, 0);
    play(0, 2, 2, 0, 0, 0); play(1, 0, 2, 0, 0, 0);
    play(0, 2, 3, 0, 0, 0);
    check_eq("row_win_winner", 72'(winner), 72'(2'b01));
    check_eq("row_win_over", 72'(game_over), 72'(1));
    repeat (3) @(negedge clk);
    compare_all("over_hold");

    // Occupied cell is rejected.
    do_new_game();
    play(0, 1, 1, 0, 0, 0); play(1, 1, 1, 0, 0, 0);
    check_eq("occupied_cell", 72'(board[1][1]), 72'(2'b01));
    check_eq("occupied_turn", 72'(turn), 72'(1));

    // Out-of-turn request.
    do_new_game();
    poke_wrong(3, 3);

    // White anti-diagonal win.
    play(0, 5, 0, 0, 0, 0); play(1, 0, 5, 0, 0, 0);
    play(0, 4, 2, 0, 0, 0); play(1, 1, 4, 0, 0, 0);
    play(0, 0, 0, 0, 0, 0); play(1, 2, 3, 0, 0, 0);
    play(0, 5, 4, 0, 0, 0); play(1, 3, 2, 0, 0, 0);
    check_eq("anti_diag_winner", 72'(winner), 72'(2'b10));

    // Bottom edge into the corner.
    do_new_game();
    play(0, 5, 2, 0, 0, 0); play(1, 0, 0, 0, 0, 0);
    play(0, 5, 3, 0, 0, 0); play(1, 0, 2, 0, 0, 0);
    play(0, 5, 4, 0, 0, 0); play(1, 1, 4, 0, 0, 0);
    play(0, 5, 5, 0, 0, 0);
    check_eq("corner_winner", 72'(winner), 72'(2'b01));

    // Full board with runs of at most two: draw.
    do_new_game();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if ((((c >> 1) + r) & 1) == 0) bl.push_back(r * N + c);
        else wl.push_back(r * N + c);
    for (int i = 0; i < 18; i++) begin
      play(0, bl[i] / N, bl[i] % N, 0, 0, 0);
      play(1, wl[i] / N, wl[i] % N, 0, 0, 0);
    end
    check_eq("draw_winner", 72'(winner), 72'(2'b00));
    check_eq("draw_over", 72'(game_over), 72'(1));
    check_eq("draw_count", 72'(move_count), 72'(36));

    // new_game, then rst, in the second CHECK cycle of a winning move.
    for (int k = 0; k < 2; k++) begin
      do_new_game();
      play(0, 2, 0, 0, 0, 0); play(1, 0, 0, 0, 0, 0);
      play(0, 2, 1, 0, 0, 0); play(1, 0, 1, 0, 0, 0);
      play(0, 2, 2, 0, 0, 0); play(1, 0, 2, 0, 0, 0);
      play(0, 2, 3, 2, k[0], 0);
      repeat (8) @(negedge clk);
      compare_all("no_late_win");
    end

    // Random games.
    for (int g = 0; g < 8; g++) begin
      do_new_game();
      for (int a = 0; a < 60 && !m_over; a++) begin
        x  = $urandom_range(0, 19);
        rr = $urandom_range(0, 6);
        cc = $urandom_range(0, 6);
        ak = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 8) : 0;
        if (x == 0) poke_wrong(rr, cc);
        else play(m_turn, rr, cc, ak, (x == 1), (x < 4));
      end
      if (m_over) begin
        repeat (3) @(negedge clk);
        compare_all("random_over_hold");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
